// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and sizing helper for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_adder_state_t;
  function automatic int cnt_width(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ cin;
  assign carry_out = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder built on a single full_adder and a registered carry
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_width(WIDTH);
  serial_adder_state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_cout, load, last;
  full_adder u_fa (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .cin(carry),
    .sum(fa_sum),
    .carry_out(fa_cout)
  );
  assign last = cnt == CW'(WIDTH - 1);
  // shift form avoids a reversed slice when WIDTH is 1
  assign sum_nx = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  always_comb begin
    load     = start && state != RUN;
    state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      busy  <= state_nx == RUN;
      done  <= state_nx == DONE;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_nx;
        carry  <= fa_cout;
        cnt    <= cnt + CW'(1);
        if (last) begin
          sum  <= sum_nx;
          cout <= fa_cout;
        end
      end
    end
  end
endmodule
